mmcm_lock_sequencer: RTL and testbench

//  Sequences the board system-clock MMCMs: drives their shared reset, waits for
//  all LOCKED outputs, and qualifies lock with a settle window. It then releases
//  a system reset and ready flag to downstream logic. It detects loss of lock,
//  re-runs the MMCM reset, and retries on lock timeout up to a fault limit.

---
 rtl/mmcm_lock_sequencer.sv | 119 +++++++++++
 tb/tb_mmcm_lock_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mmcm_lock_sequencer.sv
// Reset/lock sequencer for the system-clock MMCMs: pulses MMCM reset, waits for
// all LOCKED, qualifies with a settle window, then releases sys reset / ready.
module mmcm_lock_sequencer #(
  parameter int NUM_MMCM      = 2,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 0
) (
  input  logic                clk_i,
  input  logic                reset,
  input  logic [NUM_MMCM-1:0] locked_i,
  input  logic                restart_i,
  output logic                mmcm_rst_o,
  output logic                sys_rst_o,
  output logic                ready_o,
  output logic                fault_o,
  output logic [2:0]          state_o,
  output logic [7:0]          retry_cnt_o,
  output logic [7:0]          lock_loss_cnt_o
);

  localparam int CNT_MAX0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > SETTLE_CYCLES) ? CNT_MAX0 : SETTLE_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    S_RESET_MMCM = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_SETTLE     = 3'd2,
    S_RUN        = 3'd3,
    S_FAULT      = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       retry_cnt, retry_n, retry_inc;
  logic [7:0]       loss_cnt, loss_n, loss_inc;

  (* ASYNC_REG = "TRUE" *) logic [NUM_MMCM-1:0] lk_meta;
  (* ASYNC_REG = "TRUE" *) logic [NUM_MMCM-1:0] lk;
  logic all_lk;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      lk_meta <= '0;
      lk      <= '0;
    end else begin
      lk_meta <= locked_i;
      lk      <= lk_meta;
    end
  end

  assign all_lk    = &lk;
  assign retry_inc = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;
  assign loss_inc  = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;

  always_comb begin
    state_n = state;
    retry_n = retry_cnt;
    loss_n  = loss_cnt;
    case (state)
      S_RESET_MMCM:
        if (cnt == CNT_W'(RST_CYCLES - 1)) state_n = S_WAIT_LOCK;
      S_WAIT_LOCK:
        if (all_lk) begin
          state_n = S_SETTLE;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_n = retry_inc;
          if (MAX_RETRIES != 0 && int'(retry_inc) >= MAX_RETRIES) state_n = S_FAULT;
          else                                                  state_n = S_RESET_MMCM;
        end
      S_SETTLE:
        if (!all_lk) begin
          state_n = S_WAIT_LOCK;
        end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_n = S_RUN;
          retry_n = '0;
        end
      S_RUN:
        if (!all_lk) begin
          state_n = S_RESET_MMCM;
          loss_n  = loss_inc;
        end
      S_FAULT: ;
      default: state_n = S_RESET_MMCM;
    endcase
    // Restart overrides the transition and any counter update tied to it.
    if (restart_i) begin
      state_n = S_RESET_MMCM;
      loss_n  = loss_cnt;
      retry_n = (state == S_FAULT) ? 8'd0 : retry_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state     <= S_RESET_MMCM;
      cnt       <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      state     <= state_n;
      retry_cnt <= retry_n;
      loss_cnt  <= loss_n;
      if (restart_i || state_n != state) cnt <= '0;
      else                               cnt <= cnt + 1'b1;
    end
  end

  assign mmcm_rst_o      = (state == S_RESET_MMCM);
  assign sys_rst_o       = (state != S_RUN);
  assign ready_o         = (state == S_RUN);
  assign fault_o         = (state == S_FAULT);
  assign state_o         = state;
  assign retry_cnt_o     = retry_cnt;
  assign lock_loss_cnt_o = loss_cnt;

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Directed bench: expected states/counters are queued with their target cycle
// and checked when the run reaches that cycle.
module tb_mmcm_lock_sequencer;

  logic       clk_i = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] locked_i = 2'b00;
  logic       restart_i = 1'b0;
  logic       mmcm_rst_o, sys_rst_o, ready_o, fault_o;
  logic [2:0] state_o;
  logic [7:0] retry_cnt_o, lock_loss_cnt_o;

  mmcm_lock_sequencer #(
    .NUM_MMCM(2), .RST_CYCLES(4), .LOCK_TIMEOUT(16), .SETTLE_CYCLES(8), .MAX_RETRIES(3)
  ) dut (
    .clk_i(clk_i), .reset(reset), .locked_i(locked_i), .restart_i(restart_i),
    .mmcm_rst_o(mmcm_rst_o), .sys_rst_o(sys_rst_o), .ready_o(ready_o), .fault_o(fault_o),
    .state_o(state_o), .retry_cnt_o(retry_cnt_o), .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc_abs = 0;
  always @(posedge clk_i) cyc_abs <= cyc_abs + 1;

  typedef struct {
    int    at;
    string tag;
    int    st;
    int    rc;
    int    lc;
  } exp_t;

  exp_t q[$];
  int   base  = 0;
  int   total = 0;
  int   bad   = 0;

  function automatic void push_exp(int n, string tag, int st, int rc, int lc);
    exp_t e;
    e.at = base + n; e.tag = tag; e.st = st; e.rc = rc; e.lc = lc;
    q.push_back(e);
  endfunction

  task automatic check(exp_t e);
    logic [6:0] obs, expv;
    logic [7:0] erc, elc;
    if (e.at != cyc_abs) begin
      total++;
      assert (e.at === cyc_abs) else begin
        bad++;
        $error("FAIL %s missed: observed cycle=%0d expected cycle=%0d", e.tag, cyc_abs, e.at);
      end
      return;
    end
    obs  = {state_o, mmcm_rst_o, sys_rst_o, ready_o, fault_o};
    expv = {3'(e.st), e.st == 0, e.st != 3, e.st == 3, e.st == 4};
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s state/outs: observed=%b expected=%b", e.tag, obs, expv);
    end
    if (e.rc >= 0) begin
      erc = 8'(e.rc);
      total++;
      assert (retry_cnt_o === erc) else begin
        bad++;
        $error("FAIL %s retry_cnt: observed=%0d expected=%0d", e.tag, retry_cnt_o, erc);
      end
    end
    if (e.lc >= 0) begin
      elc = 8'(e.lc);
      total++;
      assert (lock_loss_cnt_o === elc) else begin
        bad++;
        $error("FAIL %s lock_loss_cnt: observed=%0d expected=%0d", e.tag, lock_loss_cnt_o, elc);
      end
    end
  endtask

  // Advance to the next falling edge and retire every expectation now due.
  task automatic tick();
    @(negedge clk_i);
    while (q.size() > 0 && q[0].at <= cyc_abs) check(q.pop_front());
  endtask

  task automatic wait_cyc(int n);
    while (cyc_abs < base + n) tick();
  endtask

  task automatic do_reset(logic [1:0] lk);
    reset = 1'b1; locked_i = lk; restart_i = 1'b0;
    repeat (3) tick();
    base  = cyc_abs;
    reset = 1'b0;
  endtask

  task automatic wait_ready(string tag);
    int guard = 0;
    while (ready_o && guard < 50) begin tick(); guard++; end
    while (!ready_o && guard < 50) begin tick(); guard++; end
    total++;
    assert (guard < 50) else begin
      bad++;
      $error("FAIL %s timeout: observed wait=%0d expected below 50", tag, guard);
    end
  endtask

  initial begin
    // A: clean lock, RUN lock glitch, then reset mid-SETTLE
    do_reset(2'b11);
    push_exp(1,  "t1_reset",     0, 0, 0);
    push_exp(3,  "t1_rst_last",  0, -1, -1);
    push_exp(4,  "t1_wait",      1, 0, -1);
    push_exp(5,  "t1_settle",    2, 0, -1);
    push_exp(12, "t1_settle_end",2, -1, -1);
    push_exp(13, "t1_run",       3, 0, 0);
    push_exp(22, "t3_pre",       3, 0, 0);
    push_exp(23, "t3_drop",      0, 0, 1);
    push_exp(35, "t3_settle",    2, -1, 1);
    push_exp(36, "t3_run",       3, 0, 1);
    push_exp(43, "t6a_drop",     0, 0, 2);
    push_exp(48, "t6a_settle",   2, -1, 2);
    push_exp(51, "t6a_reset",    0, 0, 0);
    wait_cyc(20); locked_i = 2'b10;
    wait_cyc(21); locked_i = 2'b11;
    wait_cyc(40); locked_i = 2'b01;
    wait_cyc(41); locked_i = 2'b11;
    wait_cyc(50); reset = 1'b1;
    wait_cyc(52);

    // B: settle glitch, then restart coinciding with a RUN lock drop
    do_reset(2'b11);
    push_exp(10, "t4_settle_c5", 2, 0, -1);
    push_exp(12, "t4_settle_c7", 2, -1, -1);
    push_exp(13, "t4_back_wait", 1, 0, -1);
    push_exp(14, "t4_resettle",  2, 0, -1);
    push_exp(21, "t4_settle_end",2, -1, -1);
    push_exp(22, "t4_run",       3, 0, 0);
    push_exp(27, "t6b_pre",      3, -1, 0);
    push_exp(28, "t6b_restart",  0, 0, 0);
    push_exp(32, "t6b_wait",     1, -1, 0);
    push_exp(41, "t6b_run",      3, 0, 0);
    wait_cyc(10); locked_i = 2'b01;
    wait_cyc(11); locked_i = 2'b11;
    wait_cyc(25); locked_i = 2'b10;
    wait_cyc(26); locked_i = 2'b11;
    wait_cyc(27); restart_i = 1'b1;
    wait_cyc(28); restart_i = 1'b0;
    wait_cyc(42);

    // C: lock never completes -> FAULT, then restart recovers
    do_reset(2'b01);
    push_exp(19, "t2_wait1_end", 1, 0, -1);
    push_exp(20, "t2_retry1",    0, 1, -1);
    push_exp(40, "t2_retry2",    0, 2, -1);
    push_exp(59, "t2_wait3_end", 1, 2, -1);
    push_exp(60, "t2_fault",     4, 3, -1);
    push_exp(70, "t2_fault_hold",4, 3, -1);
    push_exp(76, "t5_restart",   0, 0, 0);
    push_exp(79, "t5_rst_last",  0, 0, -1);
    push_exp(80, "t5_wait",      1, 0, -1);
    push_exp(89, "t5_run",       3, 0, 0);
    wait_cyc(75); locked_i = 2'b11; restart_i = 1'b1;
    wait_cyc(76); restart_i = 1'b0;
    wait_cyc(90);

    // D: lock-loss counter saturation
    for (int i = 0; i < 300; i++) begin
      if (i > 0) wait_ready("t6c_relock");
      if (i == 10) push_exp(cyc_abs - base + 1, "t6c_mid", 3, 0, 10);
      locked_i = 2'b00;
      tick();
      locked_i = 2'b11;
    end
    wait_ready("t6c_final");
    push_exp(cyc_abs - base + 1, "t6c_sat", 3, 0, 255);
    repeat (3) tick();

    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL queue_drain: observed pending=%0d expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
